// File: rtl/seq_multiplier.sv
// Unsigned N x N shift-add multiplier driving an external N-bit adder.
// One add/shift step per cycle; the product is registered with the done pulse.
module seq_multiplier #(
    parameter int N = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] product,
    output logic [N-1:0]   add_a,
    output logic [N-1:0]   add_b,
    output logic           add_cin,
    input  logic [N:0]     add_sum
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [N-1:0]  m_reg;
    logic [N-1:0]  a_reg;
    logic [N-1:0]  q_reg;
    logic [CW-1:0] cnt;
    logic [N-1:0]  a_step;
    logic [N-1:0]  q_step;

    // Carry lands in A's MSB; the dropped bit of A shifts into Q's MSB.
    assign a_step = add_sum[N:1];
    assign q_step = {add_sum[0], q_reg[N-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        add_a      = '0;
        add_b      = '0;
        add_cin    = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                busy  = 1'b1;
                add_a = a_reg;
                add_b = q_reg[0] ? m_reg : '0;
                if (cnt == LAST) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_reg   <= '0;
            a_reg   <= '0;
            q_reg   <= '0;
            cnt     <= '0;
            product <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        m_reg <= a;
                        q_reg <= b;
                        a_reg <= '0;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    a_reg <= a_step;
                    q_reg <= q_step;
                    // Hold cnt on the last step so it never wraps.
                    if (cnt == LAST) begin
                        product <= {a_step, q_step};
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed checks of seq_multiplier at N=8 plus a randomised sweep at N=32.
// The external ripple adder is modelled behaviourally in this bench.
module tb_seq_multiplier;

    logic clk;
    logic rst_n;
    int   nchecks;
    int   nerr;
    int   cyc;

    logic        start8;
    logic [7:0]  a8;
    logic [7:0]  b8;
    logic        busy8;
    logic        done8;
    logic [15:0] product8;
    logic [7:0]  add_a8;
    logic [7:0]  add_b8;
    logic        add_cin8;
    logic [8:0]  add_sum8;

    logic        start32;
    logic [31:0] a32;
    logic [31:0] b32;
    logic        busy32;
    logic        done32;
    logic [63:0] product32;
    logic [31:0] add_a32;
    logic [31:0] add_b32;
    logic        add_cin32;
    logic [32:0] add_sum32;

    int   carry_seen;
    int   cin_bad;
    int   done_seen;

    assign add_sum8  = {1'b0, add_a8} + {1'b0, add_b8} + 9'(add_cin8);
    assign add_sum32 = {1'b0, add_a32} + {1'b0, add_b32} + 33'(add_cin32);

    seq_multiplier #(.N(8)) dut8 (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start8),
        .a       (a8),
        .b       (b8),
        .busy    (busy8),
        .done    (done8),
        .product (product8),
        .add_a   (add_a8),
        .add_b   (add_b8),
        .add_cin (add_cin8),
        .add_sum (add_sum8)
    );

    seq_multiplier #(.N(32)) dut32 (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start32),
        .a       (a32),
        .b       (b32),
        .busy    (busy32),
        .done    (done32),
        .product (product32),
        .add_a   (add_a32),
        .add_b   (add_b32),
        .add_cin (add_cin32),
        .add_sum (add_sum32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (add_sum8[8] === 1'b1) carry_seen <= carry_seen + 1;
        if (add_cin32 !== 1'b0) cin_bad <= cin_bad + 1;
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        nchecks++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the done cycle.
    // poke > 0 raises start with a=b=1 at that busy cycle.
    task automatic op8(input logic [7:0] x, input logic [7:0] y,
                       input logic [15:0] exp, input int poke,
                       output int done_at);
        int          lat;
        logic [15:0] prev;
        prev   = product8;
        a8     = x;
        b8     = y;
        start8 = 1'b1;
        @(negedge clk);
        lat = 1;
        while (done8 !== 1'b1 && lat < 20) begin
            start8 = (lat == poke);
            a8     = (lat == poke) ? 8'd1 : ~x;
            b8     = (lat == poke) ? 8'd1 : ~y;
            check("busy_run", 64'(busy8), 64'd1);
            check("prod_hold", 64'(product8), 64'(prev));
            @(negedge clk);
            lat++;
        end
        start8  = 1'b0;
        done_at = cyc;
        check("latency", 64'(lat), 64'd9);
        check("busy_done", 64'(busy8), 64'd1);
        check("product8", 64'(product8), 64'(exp));
        @(negedge clk);
        check("done_pulse", 64'(done8), 64'd0);
        check("busy_idle", 64'(busy8), 64'd0);
        check("prod_keep", 64'(product8), 64'(exp));
    endtask

    task automatic op32(input logic [31:0] x, input logic [31:0] y);
        int lat;
        a32     = x;
        b32     = y;
        start32 = 1'b1;
        @(negedge clk);
        start32 = 1'b0;
        a32     = ~x;
        b32     = ~y;
        lat     = 1;
        while (done32 !== 1'b1 && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        check("latency32", 64'(lat), 64'd33);
        check("product32", product32, 64'(x) * 64'(y));
        @(negedge clk);
    endtask

    initial begin
        int t0;
        int t1;
        nchecks    = 0;
        nerr       = 0;
        cyc        = 0;
        carry_seen = 0;
        cin_bad    = 0;
        rst_n      = 1'b0;
        start8     = 1'b0;
        a8         = '0;
        b8         = '0;
        start32    = 1'b0;
        a32        = '0;
        b32        = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy8), 64'd0);
        check("rst_done", 64'(done8), 64'd0);
        check("rst_prod", 64'(product8), 64'd0);
        check("rst_add_a", 64'(add_a8), 64'd0);
        check("rst_add_b", 64'(add_b8), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        op8(8'd3, 8'd5, 16'd15, 0, t0);

        carry_seen = 0;
        op8(8'd255, 8'd255, 16'hFE01, 0, t0);
        check("carry_seen", 64'(carry_seen != 0), 64'd1);

        op8(8'd0, 8'd200, 16'd0, 0, t0);
        op8(8'd200, 8'd0, 16'd0, 0, t1);
        check("b2b_gap", 64'(t1 - t0), 64'd10);

        op8(8'd12, 8'd10, 16'd120, 4, t0);

        a8     = 8'd7;
        b8     = 8'd9;
        start8 = 1'b1;
        @(negedge clk);
        start8    = 1'b0;
        done_seen = 0;
        for (int i = 1; i < 5; i++) begin
            if (done8 === 1'b1) done_seen++;
            @(negedge clk);
        end
        check("busy_pre_rst", 64'(busy8), 64'd1);
        rst_n = 1'b0;
        #1;
        check("arst_busy", 64'(busy8), 64'd0);
        check("arst_done", 64'(done8), 64'd0);
        check("arst_prod", 64'(product8), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (done8 === 1'b1) done_seen++;
            @(negedge clk);
        end
        check("no_done_rst", 64'(done_seen), 64'd0);
        check("prod_after_rst", 64'(product8), 64'd0);
        op8(8'd7, 8'd9, 16'd63, 0, t0);

        op32(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        op32(32'h0000_0000, 32'h1234_5678);
        for (int i = 0; i < 998; i++) begin
            op32($urandom, $urandom);
        end
        check("add_cin32", 64'(cin_bad), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end

endmodule
